// File: rtl/muldiv_iter_if.sv
// Handshake bundle between execute and the iterative multiply/divide unit.
// master = issuing stage, slave = muldiv_iter.
interface muldiv_iter_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;

   modport master (
      output in_valid, op, a, b, flush, out_ready,
      input  in_ready, out_valid, hi, lo, busy
   );

   modport slave (
      input  in_valid, op, a, b, flush, out_ready,
      output in_ready, out_valid, hi, lo, busy
   );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU: one bit per cycle, result WIDTH cycles after accept (divide-by-zero: next cycle).
// Accepts only in IDLE; result is held in DONE until out_ready, flush aborts to IDLE from any state.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input logic           clk,
   input logic           resetn,
   muldiv_iter_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   abs_b;
   logic [2*WIDTH-1:0] acc;      // MUL: {partial product, multiplier}; DIV: low half holds dividend/quotient
   logic [WIDTH:0]     rem;
   logic               neg_q;
   logic               neg_r;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               out_valid_q;
   logic               busy_q;

   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   abs_a_in;
   logic [WIDTH-1:0]   abs_b_in;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH+1:0]   div_diff;
   logic               div_ok;
   logic [WIDTH:0]     rem_next;
   logic [WIDTH-1:0]   quo_next;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic               last_iter;

   always_comb begin
      sign_a   = ~bus.op[0] & bus.a[WIDTH-1];
      sign_b   = ~bus.op[0] & bus.b[WIDTH-1];
      abs_a_in = sign_a ? -bus.a : bus.a;
      abs_b_in = sign_b ? -bus.b : bus.b;

      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? abs_b : {WIDTH{1'b0}})};
      mul_next = {mul_sum, acc[WIDTH-1:1]};
      prod_fix = neg_q ? -mul_next : mul_next;

      // Restoring step: remainder stays below the divisor, so rem[WIDTH] is always 0 here.
      div_diff = {rem, acc[WIDTH-1]} - {2'b00, abs_b};
      div_ok   = ~div_diff[WIDTH+1];
      rem_next = div_ok ? div_diff[WIDTH:0] : {rem[WIDTH-1:0], acc[WIDTH-1]};
      quo_next = {acc[WIDTH-2:0], div_ok};
      quo_fix  = neg_q ? -quo_next : quo_next;
      rem_fix  = neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];

      last_iter = (cnt == CW'(1));
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         cnt         <= '0;
         abs_b       <= '0;
         acc         <= '0;
         rem         <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else if (bus.flush) begin
         state       <= IDLE;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  abs_b <= abs_b_in;
                  acc   <= {{WIDTH{1'b0}}, abs_a_in};
                  rem   <= '0;
                  cnt   <= CW'(WIDTH);
                  neg_q <= sign_a ^ sign_b;
                  neg_r <= sign_a;
                  if (!bus.op[1]) begin
                     state  <= MUL;
                     busy_q <= 1'b1;
                  end else if (bus.b != '0) begin
                     state  <= DIV;
                     busy_q <= 1'b1;
                  end else begin
                     state       <= DONE;
                     out_valid_q <= 1'b1;
                     hi_q        <= bus.a;
                     lo_q        <= '1;
                  end
               end
            end
            MUL: begin
               acc <= mul_next;
               cnt <= cnt - CW'(1);
               if (last_iter) begin
                  hi_q        <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_q        <= prod_fix[WIDTH-1:0];
                  state       <= DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            DIV: begin
               acc[WIDTH-1:0] <= quo_next;
               rem            <= rem_next;
               cnt            <= cnt - CW'(1);
               if (last_iter) begin
                  hi_q        <= rem_fix;
                  lo_q        <= quo_fix;
                  state       <= DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Randomised and directed bench for muldiv_iter (WIDTH=32) against a plain-arithmetic reference model.
module tb_muldiv_iter;
   localparam int W = 32;

   logic clk    = 1'b0;
   logic resetn = 1'b1;
   always #5 clk = ~clk;

   muldiv_iter_if #(.WIDTH(W)) bus ();

   muldiv_iter #(.WIDTH(W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] last_hi = '0;
   logic [W-1:0] last_lo = '0;

   function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] h, output logic [W-1:0] l);
      longint sa, sb, q, r;
      logic [2*W-1:0] p;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      h = '0;
      l = '0;
      case (op)
         2'd0: begin q = sa * sb; p = q; h = p[2*W-1:W]; l = p[W-1:0]; end
         2'd1: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; h = p[2*W-1:W]; l = p[W-1:0]; end
         2'd2: begin
            if (b == '0) begin h = a; l = '1; end
            else begin
               q = sa / sb; r = sa % sb;
               p = q; l = p[W-1:0];
               p = r; h = p[W-1:0];
            end
         end
         default: begin
            if (b == '0) begin h = a; l = '1; end
            else begin l = a / b; h = a % b; end
         end
      endcase
   endfunction

   // Issue one op from IDLE (called #1 after an edge); lat = edges after the accept edge until out_valid seen.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit consume,
                         output logic [W-1:0] ghi, output logic [W-1:0] glo, output int lat, output int bcnt);
      bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom_range(0, 3));
      lat = 0; bcnt = 0;
      while (bus.out_valid !== 1'b1 && lat < 200) begin
         if (bus.busy === 1'b1) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      ghi = bus.hi; glo = bus.lo;
      if (consume) begin
         bus.out_ready = 1'b1;
         @(posedge clk); #1;
         bus.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset;
      #1 resetn = 1'b0;
      #1;
      checks++;
      if (bus.hi !== '0 || bus.lo !== '0) begin
         failures++; $display("FAIL reset_hilo: hi=%h lo=%h want 0/0", bus.hi, bus.lo);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_ctrl: out_valid=%b busy=%b in_ready=%b want 0/0/1",
                              bus.out_valid, bus.busy, bus.in_ready);
      end
      #19 resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mul_directed;
      logic [1:0]   ops [3] = '{2'd1, 2'd0, 2'd0};
      logic [W-1:0] as  [3] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000};
      logic [W-1:0] bs  [3] = '{32'hFFFFFFFF, 32'h00000007, 32'h80000000};
      logic [W-1:0] ehs [3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000};
      logic [W-1:0] els [3] = '{32'h00000001, 32'hFFFFFFEB, 32'h00000000};
      logic [W-1:0] gh, gl;
      int lat, bc;
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i], as[i], bs[i], 1'b1, gh, gl, lat, bc);
         checks++;
         if (gh !== ehs[i] || gl !== els[i]) begin
            failures++; $display("FAIL mul_dir%0d: hi=%h lo=%h want %h %h", i, gh, gl, ehs[i], els[i]);
         end
         checks++;
         if (lat != W || bc != W) begin
            failures++; $display("FAIL mul_dir%0d_timing: lat=%0d busy=%0d want %0d/%0d", i, lat, bc, W, W);
         end
         last_hi = ehs[i]; last_lo = els[i];
      end
   endtask

   task automatic test_div_directed;
      logic [1:0]   ops [3] = '{2'd2, 2'd2, 2'd3};
      logic [W-1:0] as  [3] = '{32'hFFFFFFF9, 32'h80000000, 32'd100};
      logic [W-1:0] bs  [3] = '{32'd2, 32'hFFFFFFFF, 32'd7};
      logic [W-1:0] ehs [3] = '{32'hFFFFFFFF, 32'h0, 32'd2};
      logic [W-1:0] els [3] = '{32'hFFFFFFFD, 32'h80000000, 32'd14};
      logic [W-1:0] gh, gl;
      int lat, bc;
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i], as[i], bs[i], 1'b1, gh, gl, lat, bc);
         checks++;
         if (gh !== ehs[i] || gl !== els[i] || lat != W) begin
            failures++; $display("FAIL div_dir%0d: hi=%h lo=%h lat=%0d want %h %h %0d",
                                 i, gh, gl, lat, ehs[i], els[i], W);
         end
         last_hi = ehs[i]; last_lo = els[i];
      end
   endtask

   task automatic test_div_zero;
      logic [1:0]   ops [2] = '{2'd3, 2'd2};
      logic [W-1:0] as  [2] = '{32'd5, 32'hFFFFFFFB};
      logic [W-1:0] gh, gl;
      int lat, bc;
      for (int i = 0; i < 2; i++) begin
         run_op(ops[i], as[i], '0, 1'b1, gh, gl, lat, bc);
         checks++;
         if (gh !== as[i] || gl !== 32'hFFFFFFFF) begin
            failures++; $display("FAIL div0_%0d: hi=%h lo=%h want %h ffffffff", i, gh, gl, as[i]);
         end
         checks++;
         if (lat != 0 || bc != 0) begin
            failures++; $display("FAIL div0_%0d_timing: lat=%0d busy=%0d want 0/0", i, lat, bc);
         end
         last_hi = as[i]; last_lo = '1;
      end
   endtask

   task automatic test_random;
      logic [1:0]   op;
      logic [W-1:0] a, b, eh, el, gh, gl;
      int lat, bc, elat, sel;
      for (int i = 0; i < 60; i++) begin
         op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) b = '0;
         else if (sel == 1) begin a = 32'h80000000; b = '1; end
         else if (sel == 2) b = 32'($urandom_range(1, 15));
         else if (sel == 3) a = 32'($urandom_range(0, 50));
         ref_model(op, a, b, eh, el);
         elat = (op[1] && b == '0) ? 0 : W;
         run_op(op, a, b, 1'b1, gh, gl, lat, bc);
         checks++;
         if (gh !== eh || gl !== el || lat != elat) begin
            failures++; $display("FAIL rand%0d op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d want %h %h %0d",
                                 i, op, a, b, gh, gl, lat, eh, el, elat);
         end
         last_hi = eh; last_lo = el;
      end
   endtask

   task automatic test_flush;
      logic [W-1:0] gh, gl;
      int lat, bc;
      bit seen;
      bus.op = 2'd3; bus.a = 32'd1000; bus.b = 32'd3; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL flush_idle: busy=%b out_valid=%b in_ready=%b want 0/0/1",
                              bus.busy, bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.hi !== last_hi || bus.lo !== last_lo) begin
         failures++; $display("FAIL flush_hold: hi=%h lo=%h want %h %h", bus.hi, bus.lo, last_hi, last_lo);
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++; $display("FAIL flush_no_valid: out_valid rose=1 want 0");
      end
      bus.op = 2'd1; bus.a = 32'd9; bus.b = 32'd9; bus.in_valid = 1'b1; bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.flush = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL flush_no_accept: busy=%b in_ready=%b want 0/1", bus.busy, bus.in_ready);
      end
      run_op(2'd1, 32'd3, 32'd4, 1'b1, gh, gl, lat, bc);
      checks++;
      if (gh !== 32'd0 || gl !== 32'd12 || lat != W) begin
         failures++; $display("FAIL flush_after: hi=%h lo=%h lat=%0d want 0 c %0d", gh, gl, lat, W);
      end
      last_hi = 32'd0; last_lo = 32'd12;
   endtask

   task automatic test_done_hold;
      logic [W-1:0] eh, el, gh, gl;
      int lat, bc;
      ref_model(2'd1, 32'h12345678, 32'h9ABCDEF0, eh, el);
      run_op(2'd1, 32'h12345678, 32'h9ABCDEF0, 1'b0, gh, gl, lat, bc);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.hi !== eh || bus.lo !== el) begin
            failures++; $display("FAIL done_hold%0d: out_valid=%b in_ready=%b hi=%h lo=%h want 1 0 %h %h",
                                 i, bus.out_valid, bus.in_ready, bus.hi, bus.lo, eh, el);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL done_release: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
      end
      last_hi = eh; last_lo = el;
   endtask

   task automatic test_reset_mid;
      bus.op = 2'd0; bus.a = 32'hFFFFFFFD; bus.b = 32'd7; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++; $display("FAIL rst_mid_busy: busy=%b want 1", bus.busy);
      end
      #1 resetn = 1'b0;
      #1;
      checks++;
      if (bus.hi !== '0 || bus.lo !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL rst_mid: hi=%h lo=%h out_valid=%b busy=%b in_ready=%b want 0 0 0 0 1",
                              bus.hi, bus.lo, bus.out_valid, bus.busy, bus.in_ready);
      end
      @(negedge clk);
      resetn = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         failures++; $display("FAIL rst_mid_after: out_valid=%b busy=%b want 0/0", bus.out_valid, bus.busy);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
      bus.flush = 1'b0; bus.out_ready = 1'b0;
      test_reset();
      test_mul_directed();
      test_div_directed();
      test_div_zero();
      test_random();
      test_flush();
      test_done_hold();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
Parametrised iterative multiply/divide unit for the execute stage. It generalises the fixed 32-bit multicycle HI/LO unit with a WIDTH parameter and valid/ready handshakes on both sides. It adds a working flush input and defined divide-by-zero and signed-overflow results. Execute issues MULT/MULTU/DIV/DIVU here; hazard logic stalls on busy/out_valid, and the results feed the HI/LO write path.

Parameters:
WIDTH, 32, operand width in bits; must be >= 2; hi/lo are WIDTH each.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  unit can accept; high only in IDLE
op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  in  WIDTH  multiplicand / dividend
b  in  WIDTH  multiplier / divisor
flush  in  1  abort current operation (exception/redirect)
out_valid  out  1  result ready; high only in DONE
out_ready  in  1  consumer takes result
hi  out  WIDTH  MUL: upper product; DIV: remainder
lo  out  WIDTH  MUL: lower product; DIV: quotient
busy  out  1  high in MUL or DIV states

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (resetn). Reset forces IDLE, hi=lo=0, out_valid=0, busy=0, counter=0, all internal registers 0. Reset mid-operation discards the operation immediately.
- States: IDLE, MUL, DIV, DONE.
- Accept: in_valid & in_ready & ~flush at a rising edge. Latch op, the sign flags, |a| and |b| (abs only for signed ops; two's complement mod 2^WIDTH, so |MIN| = MIN as an unsigned bit pattern). Load counter=WIDTH.
- Accept with op MULT/MULTU -> MUL.
- Accept with op DIV/DIVU and b != 0 -> DIV.
- Accept with op DIV/DIVU and b == 0 -> DONE directly. Result lo = all ones, hi = a (raw). Latency 1 cycle.
- MUL: shift-add, one multiplier bit per cycle. 2*WIDTH-bit accumulator.
- DIV: restoring division, one quotient bit per cycle. WIDTH+1-bit partial remainder.
- Counter decrements each iteration cycle. On the edge where the last (WIDTH-th) iteration completes:
  - Apply sign correction and write hi/lo.
  - Go to DONE.
  - Accept at edge E gives out_valid from edge E+WIDTH.
- Sign rules:
  - MULT: product negated (2*WIDTH bits) iff sign(a) != sign(b).
  - DIV: quotient negated iff sign(a) != sign(b); remainder takes the sign of the dividend.
  - DIV MIN / -1 gives lo = MIN, hi = 0, with no flag.
- DONE: out_valid=1; hi/lo stable. On out_valid & out_ready -> IDLE next edge. in_ready=0 in DONE, so there is no same-cycle accept.
- hi/lo update only on completion. They otherwise hold the last completed result, including through flush and IDLE.
- flush: has priority over everything except reset. In any state, the next edge goes to IDLE, out_valid=0, busy=0, hi/lo unchanged. A request with in_valid in the same cycle as flush is not accepted.
- Operand inputs are ignored after the accept edge. Changing a/b/op mid-operation has no effect.
- in_ready is a function of state only. There is no combinational path from in_valid or out_ready to in_ready.

Test Plan:
1. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF (WIDTH=32) -> hi=0xFFFFFFFE, lo=0x00000001. out_valid exactly 32 cycles after the accept edge; busy high for those 32 cycles.
2. MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 100/7 -> lo=14, hi=2.
4. DIVU a=5, b=0 -> out_valid the cycle after accept; lo=0xFFFFFFFF, hi=5. DIV a=-5, b=0 -> lo=0xFFFFFFFF, hi=0xFFFFFFFB.
5. DIVU started, flush pulsed at iteration 10 -> IDLE next cycle, out_valid never rises, hi/lo keep the prior result. Flush with in_valid in the same cycle -> no accept. The next MULTU 3*4 -> lo=12, hi=0.
6. Hold out_ready=0 for 5 cycles in DONE -> out_valid, hi, lo stable, in_ready=0. Assert resetn=0 mid-MUL -> all outputs 0 asynchronously, before the next clk edge.
